// File: rtl/cc14_feedback_decoder_pkg.sv
// Shared constants and types for the Convolutional_Code_14 feedback decoder.
// Tap masks are indexed by encoder register number (bit i = register ri).
package cc14_pkg;

  localparam int NUM_REGS = 14;

  localparam logic [NUM_REGS-1:0] G1_TAPS = 14'h2F72;  // r1,4,5,6,8,9,10,11,13
  localparam logic [NUM_REGS-1:0] G2_TAPS = 14'h329D;  // r0,2,3,4,7,9,12,13

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    LOST   = 2'd2
  } mon_state_t;

  function automatic logic tap_xor(input logic [NUM_REGS-1:0] regs,
                                   input logic [NUM_REGS-1:0] taps);
    return ^(regs & taps);
  endfunction

endpackage

// File: rtl/cc14_feedback_decoder_if.sv
// Symbol-in / decoded-bit-out handshake bundle for the feedback decoder.
interface cc14_feedback_decoder_if;

  logic sym_valid;
  logic sym_ready;
  logic sym1;
  logic sym2;
  logic dout_valid;
  logic dout_ready;
  logic dout;
  logic dout_perr;

  modport master (
    output sym_valid, sym1, sym2, dout_ready,
    input  sym_ready, dout_valid, dout, dout_perr
  );

  modport slave (
    input  sym_valid, sym1, sym2, dout_ready,
    output sym_ready, dout_valid, dout, dout_perr
  );

endinterface

// File: rtl/cc14_err_monitor.sv
// Sync monitor: per-window parity error count drives IDLE/LOCKED/LOST,
// plus a saturating lifetime parity error counter.
module cc14_err_monitor
  import cc14_pkg::*;
#(
  parameter int ERR_WIN    = 32,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_acc,
  input  logic             i_perr,
  input  logic             i_restart,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int WC_W = $clog2(ERR_WIN);
  localparam int WE_W = $clog2(ERR_WIN + 1);

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic [WC_W-1:0]  r_win_cnt;
  logic [WE_W-1:0]  r_win_err;
  logic [CNT_W-1:0] r_err_count;
  logic [WE_W:0]    w_err_sum;
  logic             w_thresh_hit;
  logic             w_win_last;

  // The symbol being accepted counts toward its own window's threshold.
  assign w_err_sum    = {1'b0, r_win_err} + {{WE_W{1'b0}}, i_perr};
  assign w_thresh_hit = w_err_sum >= (WE_W+1)'(ERR_THRESH);
  assign w_win_last   = r_win_cnt == WC_W'(ERR_WIN - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_restart) begin
      w_state_nxt = IDLE;
    end else if (i_acc) begin
      case (r_state)
        IDLE:    w_state_nxt = LOCKED;
        LOCKED:  if (w_thresh_hit) w_state_nxt = LOST;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    o_locked    = (r_state == LOCKED);
    o_err_count = r_err_count;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
    end else if (i_restart) begin
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
    end else if (i_acc) begin
      if (w_win_last) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_win_err <= w_err_sum[WE_W-1:0];
      end
      if (i_perr && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule

// File: rtl/cc14_feedback_decoder.sv
// Feedback decoder for the rate-1/2 Convolutional_Code_14 stream: inverts the
// out2 generator to recover one bit per symbol and re-encodes out1 as a parity check.
module cc14_feedback_decoder
  import cc14_pkg::*;
#(
  parameter int ERR_WIN    = 32,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    restart,
  cc14_feedback_decoder_if.slave  sym_if,
  output logic                    locked,
  output logic [CNT_W-1:0]        err_count
);

  logic [NUM_REGS-1:1] r_hist;
  logic                r_dout_valid;
  logic                r_dout;
  logic                r_dout_perr;
  logic [NUM_REGS-1:0] w_regs;
  logic                w_ready;
  logic                w_acc;
  logic                w_b;
  logic                w_perr;

  // h0 is the unknown bit being solved for, so it enters the tap sums as 0.
  assign w_regs  = {r_hist, 1'b0};
  assign w_b     = sym_if.sym2 ^ tap_xor(w_regs, G2_TAPS);
  assign w_perr  = sym_if.sym1 ^ tap_xor(w_regs, G1_TAPS);

  assign w_ready = (~r_dout_valid | sym_if.dout_ready) & ~restart;
  assign w_acc   = sym_if.sym_valid & w_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hist       <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= 1'b0;
      r_dout_perr  <= 1'b0;
    end else if (restart) begin
      r_hist       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_acc) begin
      r_hist       <= {r_hist[NUM_REGS-2:1], w_b};
      r_dout       <= w_b;
      r_dout_perr  <= w_perr;
      r_dout_valid <= 1'b1;
    end else if (sym_if.dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign sym_if.sym_ready  = w_ready;
  assign sym_if.dout_valid = r_dout_valid;
  assign sym_if.dout       = r_dout;
  assign sym_if.dout_perr  = r_dout_perr;

  cc14_err_monitor #(
    .ERR_WIN    (ERR_WIN),
    .ERR_THRESH (ERR_THRESH),
    .CNT_W      (CNT_W)
  ) u_mon (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_acc       (w_acc),
    .i_perr      (w_perr),
    .i_restart   (restart),
    .o_locked    (locked),
    .o_err_count (err_count)
  );

endmodule

// File: doc/cc14_feedback_decoder.md
Name: cc14_feedback_decoder

Overview:
- Hard-decision decoder for the rate-1/2, 14-register Convolutional_Code_14 symbol stream.
- Recovers the input bit sequence by recursive inversion on the out2 generator. out2 taps register r0, so each symbol yields exactly one new bit.
- Re-encodes the out1 generator to produce a parity check per symbol.
- Error monitor FSM declares loss of sync and waits for an explicit restart aligned with an encoder reset/flush.

Parameters:
- ERR_WIN, 32, symbols per error-monitoring window (>=2).
- ERR_THRESH, 4, parity errors within one window that force LOST (1..ERR_WIN).
- CNT_W, 16, width of the saturating total-parity-error counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- restart  in  1  1-cycle pulse: clear history and monitor, enter IDLE
- sym_valid  in  1  symbol pair present
- sym_ready  out  1  decoder accepts the symbol this cycle
- sym1  in  1  received out1 bit
- sym2  in  1  received out2 bit
- dout_valid  out  1  decoded bit present
- dout_ready  in  1  downstream accepts the decoded bit
- dout  out  1  decoded bit (encoder input delayed by one encoder clock)
- dout_perr  out  1  parity mismatch on the symbol that produced dout
- locked  out  1  FSM in LOCKED
- err_count  out  CNT_W  total parity errors since reset/restart, saturating

Behaviour:
- Reset (async, reset_n=0): history h[1..13]=0, FSM=IDLE, dout_valid=0, dout=0, dout_perr=0, locked=0, err_count=0, window counters=0.
- sym_ready = ~dout_valid | dout_ready. It is forced to 0 in the cycle restart=1.
- Accept occurs when sym_valid & sym_ready.
- On accept:
  - b = sym2 ^ h2^h3^h4^h7^h9^h12^h13.
  - e1 = h1^h4^h5^h6^h8^h9^h10^h11^h13.
  - perr = sym1 ^ e1.
  - Next cycle: h1<=b, h[i]<=h[i-1] for i=2..13; dout<=b; dout_perr<=perr; dout_valid<=1.
- Latency: exactly 1 clock from accept to dout_valid.
- dout_valid clears when dout_ready=1 and no new accept occurs that cycle. Simultaneous pop and accept keeps dout_valid=1 with the new data.
- dout/dout_perr hold stable while dout_valid & ~dout_ready.
- Decoding continues in every FSM state; the FSM affects only locked and the monitor.
- err_count increments on each accepted perr=1 and saturates at 2^CNT_W-1.
- FSM states:
  - IDLE: first accept -> LOCKED.
  - LOCKED: window error count reaching ERR_THRESH -> LOST.
  - LOST: stays until restart.
- Window monitor:
  - win_cnt counts accepts 0..ERR_WIN-1 and wraps.
  - win_err counts perr within the window.
  - On the accept where win_cnt=ERR_WIN-1, both clear after evaluation; the last symbol of the window is counted before clearing.
  - LOCKED->LOST is evaluated on win_err+perr >= ERR_THRESH at the accepting edge.
- restart (synchronous, any state):
  - Clears h, win_cnt, win_err, err_count, dout_valid; FSM=IDLE.
  - restart takes priority over a same-cycle accept; sym_ready is 0, so no accept occurs.
- Mid-stream reset_n assertion: immediate clear as above. A pending dout is discarded.
- The encoder and decoder must both start from zero state. A single channel error propagates through h; recovery is only via restart paired with an encoder reset or a 14-zero flush.

Decomposition:
- Package cc14_pkg holds:
  - G1_TAPS = 14-bit mask {1,4,5,6,8,9,10,11,13}
  - G2_TAPS = mask {0,2,3,4,7,9,12,13}
  - NUM_REGS = 14
  - mon_state_t enum {IDLE, LOCKED, LOST}
- Tap XORs use masked reduction over h with h0 excluded/substituted.
- Sub-module cc14_err_monitor owns win_cnt, win_err, err_count and the FSM. Inputs: acc, perr, restart. Outputs: locked, err_count.

Test Plan:
- Impulse: feed (sym1,sym2) sequence (0,1),(1,0),(0,1),(0,1),(1,1),(1,0),(1,0),(0,1),(1,0),(1,1),(1,0),(1,0),(0,1),(1,1), then (0,0) x10 -> dout = 1 followed by 23 zeros; dout_perr never 1; locked=1 after first accept; err_count=0.
- Loopback: drive a random 1000-bit stream into Convolutional_Code_14 and feed its outputs starting with the first post-reset symbol -> dout equals encoder input delayed by one, zero perr.
- Single-bit error: flip sym1 on symbol 50 of loopback -> dout_perr=1 on that symbol only, err_count=1, dout unchanged, locked stays 1.
- Loss of sync: flip sym2 on symbol 40 -> propagated errors hit ERR_THRESH=4 within the window -> locked=0. Then assert restart, reset the encoder and resume -> IDLE, then LOCKED on the next accept, err_count=0.
- Backpressure: hold dout_ready=0 for 5 cycles with sym_valid=1 -> exactly one symbol accepted, sym_ready=0, dout stable. Release -> one bit per cycle, no loss or duplication.
- Async reset mid-stream: pull reset_n low between clock edges with dout_valid=1 -> dout_valid, locked and err_count are 0 immediately, and the history is cleared.
